// File: rtl/anc_pkg.sv
// Shared ANC definitions: sample width and the frame bundle handed from ingress
// to the controller.
package anc_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    sample_t x;
    sample_t e;
    sample_t a;
    sample_t u;
  } anc_frame_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/anc_frame_fifo.sv
// First-word fall-through frame FIFO; the head is visible while not empty and
// reads as zero when empty.
module anc_frame_fifo
  import anc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  anc_frame_t    push_data,
  input  logic          pop,
  output anc_frame_t    head,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  localparam int PW = $clog2(DEPTH);

  anc_frame_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  // A push into a full FIFO still fits when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop) && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/anc_sample_ingress.sv
// Collects x/e/a samples from independent strobes, bundles them with mu into a
// frame and queues it for the ANC controller.
module anc_sample_ingress
  import anc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LW    = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ingress_en,
  input  logic                       flush,
  input  logic                       x_smp_valid,
  input  logic signed [SAMPLE_W-1:0] x_smp,
  input  logic                       e_smp_valid,
  input  logic signed [SAMPLE_W-1:0] e_smp,
  input  logic                       a_smp_valid,
  input  logic signed [SAMPLE_W-1:0] a_smp,
  input  logic signed [SAMPLE_W-1:0] mu_cfg,
  output logic                       in_valid,
  input  logic                       controller_ready,
  output logic signed [SAMPLE_W-1:0] x_out,
  output logic signed [SAMPLE_W-1:0] e_out,
  output logic signed [SAMPLE_W-1:0] a_out,
  output logic signed [SAMPLE_W-1:0] u_out,
  output logic [LW-1:0]              fifo_level,
  output logic [7:0]                 ovf_count,
  output logic                       collision_err
);

  sample_t    x_cap, e_cap, a_cap;
  logic       have_x, have_e, have_a;
  logic       commit;
  logic       pop;
  logic       full;
  logic       empty;
  logic       drop;
  logic       collide;
  anc_frame_t head;
  anc_frame_t new_frame;

  // Handshake: a frame transfers on every edge where in_valid && controller_ready;
  // while in_valid is high and no transfer happens, the head fields hold still,
  // and in_valid only falls after a transfer, a flush or reset.
  assign pop    = in_valid && controller_ready;
  assign commit = have_x && have_e && have_a && ingress_en && !flush;
  assign drop   = commit && full && !pop;

  // Strobes landing on the commit edge refill a slot that is being emptied.
  assign collide = !commit && ((x_smp_valid && have_x) ||
                               (e_smp_valid && have_e) ||
                               (a_smp_valid && have_a));

  assign new_frame = '{x: x_cap, e: e_cap, a: a_cap, u: mu_cfg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cap         <= '0;
      e_cap         <= '0;
      a_cap         <= '0;
      have_x        <= 1'b0;
      have_e        <= 1'b0;
      have_a        <= 1'b0;
      ovf_count     <= '0;
      collision_err <= 1'b0;
    end else if (flush || !ingress_en) begin
      have_x <= 1'b0;
      have_e <= 1'b0;
      have_a <= 1'b0;
    end else begin
      if (x_smp_valid) begin
        x_cap  <= x_smp;
        have_x <= 1'b1;
      end else if (commit) begin
        have_x <= 1'b0;
      end
      if (e_smp_valid) begin
        e_cap  <= e_smp;
        have_e <= 1'b1;
      end else if (commit) begin
        have_e <= 1'b0;
      end
      if (a_smp_valid) begin
        a_cap  <= a_smp;
        have_a <= 1'b1;
      end else if (commit) begin
        have_a <= 1'b0;
      end
      if (drop)    ovf_count     <= sat_inc8(ovf_count);
      if (collide) collision_err <= 1'b1;
    end
  end

  anc_frame_fifo #(
    .DEPTH (DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (commit),
    .push_data (new_frame),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  assign in_valid = !empty;
  assign x_out    = head.x;
  assign e_out    = head.e;
  assign a_out    = head.a;
  assign u_out    = head.u;

endmodule

// File: tb/tb_anc_sample_ingress.sv
// Directed bench for anc_sample_ingress: capture, commit, backpressure,
// overflow, collision, flush, enable and async reset.
module tb_anc_sample_ingress;

  localparam int DEPTH = 4;
  localparam int LW    = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ingress_en = 1'b1;
  logic          flush = 1'b0;
  logic          x_smp_valid = 1'b0;
  logic [15:0]   x_smp = '0;
  logic          e_smp_valid = 1'b0;
  logic [15:0]   e_smp = '0;
  logic          a_smp_valid = 1'b0;
  logic [15:0]   a_smp = '0;
  logic [15:0]   mu_cfg = '0;
  logic          in_valid;
  logic          controller_ready = 1'b0;
  logic [15:0]   x_out, e_out, a_out, u_out;
  logic [LW-1:0] fifo_level;
  logic [7:0]    ovf_count;
  logic          collision_err;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [63:0] exp_q[$];
  logic [63:0] frame;

  assign frame = {x_out, e_out, a_out, u_out};

  anc_sample_ingress #(.DEPTH(DEPTH), .LW(LW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ingress_en       (ingress_en),
    .flush            (flush),
    .x_smp_valid      (x_smp_valid),
    .x_smp            (x_smp),
    .e_smp_valid      (e_smp_valid),
    .e_smp            (e_smp),
    .a_smp_valid      (a_smp_valid),
    .a_smp            (a_smp),
    .mu_cfg           (mu_cfg),
    .in_valid         (in_valid),
    .controller_ready (controller_ready),
    .x_out            (x_out),
    .e_out            (e_out),
    .a_out            (a_out),
    .u_out            (u_out),
    .fifo_level       (fifo_level),
    .ovf_count        (ovf_count),
    .collision_err    (collision_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard check
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // drivers
  task automatic strobe(input logic xv, input logic ev, input logic av,
                        input logic [15:0] xs, input logic [15:0] es, input logic [15:0] as_v);
    x_smp_valid = xv; x_smp = xs;
    e_smp_valid = ev; e_smp = es;
    a_smp_valid = av; a_smp = as_v;
    tick();
    x_smp_valid = 1'b0;
    e_smp_valid = 1'b0;
    a_smp_valid = 1'b0;
  endtask

  // all three strobes on one edge, commit on the next
  task automatic send_frame(input logic [15:0] xs, input logic [15:0] es,
                            input logic [15:0] as_v, input logic [15:0] us);
    mu_cfg = us;
    strobe(1'b1, 1'b1, 1'b1, xs, es, as_v);
    tick();
  endtask

  task automatic drain(input string tag);
    controller_ready = 1'b1;
    while (exp_q.size() > 0) begin
      check({tag, "_valid"}, 64'(in_valid), 64'd1);
      check({tag, "_frame"}, frame, exp_q.pop_front());
      tick();
    end
    check({tag, "_empty"}, 64'(in_valid), 64'd0);
  endtask

  initial begin
    // reset state
    repeat (3) tick();
    check("rst_in_valid", 64'(in_valid), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_ovf", 64'(ovf_count), 64'd0);
    check("rst_coll", 64'(collision_err), 64'd0);
    check("rst_frame", frame, 64'd0);
    rst_n = 1'b1;

    // basic frame: x at edge 1, e at edge 3, a at edge 4, commit at edge 5
    controller_ready = 1'b1;
    mu_cfg = 16'h0040;
    strobe(1'b1, 1'b0, 1'b0, 16'h0100, 16'h0, 16'h0);
    tick();
    strobe(1'b0, 1'b1, 1'b0, 16'h0, 16'hFF00, 16'h0);
    strobe(1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h7FFF);
    check("basic_pre_valid", 64'(in_valid), 64'd0);
    tick();
    check("basic_valid", 64'(in_valid), 64'd1);
    check("basic_frame", frame, 64'h0100_FF00_7FFF_0040);
    check("basic_level1", 64'(fifo_level), 64'd1);
    tick();
    check("basic_one_cycle", 64'(in_valid), 64'd0);
    check("basic_level0", 64'(fifo_level), 64'd0);

    // backpressure and overflow: six frames, last two dropped
    controller_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send_frame(16'(16'h1000 + i), 16'(16'h2000 + i), 16'(16'h3000 + i), 16'(16'h0010 + i));
    end
    exp_q.push_back(64'h1000_2000_3000_0010);
    exp_q.push_back(64'h1001_2001_3001_0011);
    exp_q.push_back(64'h1002_2002_3002_0012);
    exp_q.push_back(64'h1003_2003_3003_0013);
    check("bp_level", 64'(fifo_level), 64'd4);
    check("bp_ovf", 64'(ovf_count), 64'd2);
    check("bp_head", frame, 64'h1000_2000_3000_0010);
    drain("bp_drain");

    // full FIFO with pop and commit on the same edge
    controller_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_frame(16'(16'h4000 + i), 16'(16'h4100 + i), 16'(16'h4200 + i), 16'h0020);
    end
    check("fullpop_pre_level", 64'(fifo_level), 64'd4);
    mu_cfg = 16'h0021;
    strobe(1'b1, 1'b1, 1'b1, 16'h4004, 16'h4104, 16'h4204);
    controller_ready = 1'b1;
    tick();
    controller_ready = 1'b0;
    check("fullpop_level", 64'(fifo_level), 64'd4);
    check("fullpop_ovf", 64'(ovf_count), 64'd2);
    check("fullpop_head", frame, 64'h4001_4101_4201_0020);
    exp_q.push_back(64'h4001_4101_4201_0020);
    exp_q.push_back(64'h4002_4102_4202_0020);
    exp_q.push_back(64'h4003_4103_4203_0020);
    exp_q.push_back(64'h4004_4104_4204_0021);
    drain("fullpop_drain");

    // x strobe on the commit edge belongs to the next frame, no collision
    controller_ready = 1'b1;
    mu_cfg = 16'h0005;
    strobe(1'b1, 1'b1, 1'b1, 16'h0A0A, 16'h0B0B, 16'h0C0C);
    strobe(1'b1, 1'b0, 1'b0, 16'h0D0D, 16'h0, 16'h0);
    check("cedge_frame", frame, 64'h0A0A_0B0B_0C0C_0005);
    check("cedge_coll", 64'(collision_err), 64'd0);
    strobe(1'b0, 1'b1, 1'b1, 16'h0, 16'h0E0E, 16'h0F0F);
    tick();
    check("cedge_next_frame", frame, 64'h0D0D_0E0E_0F0F_0005);
    check("cedge_next_coll", 64'(collision_err), 64'd0);
    check("cedge_level", 64'(fifo_level), 64'd1);
    tick();

    // collision: second x overwrites the first
    strobe(1'b1, 1'b0, 1'b0, 16'h1111, 16'h0, 16'h0);
    strobe(1'b1, 1'b0, 1'b0, 16'h2222, 16'h0, 16'h0);
    check("coll_flag", 64'(collision_err), 64'd1);
    strobe(1'b0, 1'b1, 1'b1, 16'h0, 16'h3333, 16'h4444);
    tick();
    check("coll_frame", frame, 64'h2222_3333_4444_0005);
    tick();
    check("coll_drained", 64'(fifo_level), 64'd0);

    // flush with three frames queued and x pending
    controller_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_frame(16'(16'h5000 + i), 16'h5100, 16'h5200, 16'h0030);
    end
    check("flush_pre_level", 64'(fifo_level), 64'd3);
    strobe(1'b1, 1'b0, 1'b0, 16'h6666, 16'h0, 16'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_level", 64'(fifo_level), 64'd0);
    check("flush_valid", 64'(in_valid), 64'd0);
    check("flush_ovf_kept", 64'(ovf_count), 64'd2);
    check("flush_coll_kept", 64'(collision_err), 64'd1);
    strobe(1'b0, 1'b1, 1'b1, 16'h0, 16'h7777, 16'h8888);
    tick();
    check("flush_x_cleared", 64'(fifo_level), 64'd0);
    strobe(1'b1, 1'b0, 1'b0, 16'h9999, 16'h0, 16'h0);
    tick();
    check("flush_refill_level", 64'(fifo_level), 64'd1);
    check("flush_refill_frame", frame, 64'h9999_7777_8888_0030);
    controller_ready = 1'b1;
    tick();
    controller_ready = 1'b0;
    check("flush_refill_pop", 64'(fifo_level), 64'd0);

    // ingress disabled: strobes ignored; pending flags cleared
    ingress_en = 1'b0;
    strobe(1'b1, 1'b1, 1'b1, 16'hAAAA, 16'hBBBB, 16'hCCCC);
    tick();
    check("en_off_no_commit", 64'(fifo_level), 64'd0);
    ingress_en = 1'b1;
    strobe(1'b1, 1'b1, 1'b1, 16'hAAAA, 16'hBBBB, 16'hCCCC);
    ingress_en = 1'b0;
    tick();
    ingress_en = 1'b1;
    tick();
    tick();
    check("en_off_flags_cleared", 64'(fifo_level), 64'd0);
    check("en_off_valid", 64'(in_valid), 64'd0);

    // saturate the overflow counter, then async reset mid-cycle
    for (int i = 0; i < 4; i++) begin
      send_frame(16'(16'hC000 + i), 16'hC100, 16'hC200, 16'h0050);
    end
    for (int i = 0; i < 254; i++) begin
      send_frame(16'(16'hD000 + i), 16'hD100, 16'hD200, 16'h0060);
    end
    check("sat_ovf", 64'(ovf_count), 64'd255);
    check("sat_head", frame, 64'hC000_C100_C200_0050);
    controller_ready = 1'b1;
    tick();
    tick();
    controller_ready = 1'b0;
    check("arst_pre_level", 64'(fifo_level), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(in_valid), 64'd0);
    check("arst_level", 64'(fifo_level), 64'd0);
    check("arst_ovf", 64'(ovf_count), 64'd0);
    check("arst_coll", 64'(collision_err), 64'd0);
    check("arst_frame", frame, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_after_valid", 64'(in_valid), 64'd0);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
